// File: rtl/piece_queue_ctrl.sv
// piece_queue_ctrl
//   Holds the queue of upcoming pieces for the game controller. The queue
//   asks the piece generator for candidates while it has room. It keeps
//   accepted pieces in a circular FIFO, and it shows the head piece and
//   the piece after it to the game.
//
//   Optional feature macro: PIECE_BAG_EN
//     When it is defined, dealing follows the 7-bag rule. A piece that was
//     already dealt in the current bag is discarded. When the seventh
//     distinct piece is accepted, the bag mask is cleared.
//     When it is undefined, bag_mask is tied to 0 and no bag logic exists.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   gen_enable    out  request a new candidate from the generator
//   gen_ready     in   generator candidate valid this cycle
//   gen_piece     in   candidate code 0..6 (7 = invalid)
//   take          in   game controller pops the head piece
//   next_valid    out  queue is non-empty
//   next_piece    out  head entry (0 when empty)
//   preview_piece out  second entry (0 when fewer than two entries)
//   count         out  occupancy 0..DEPTH
//   reject_count  out  saturating count of discarded candidates
//   bag_mask      out  pieces dealt in the current bag
module piece_queue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       gen_enable,
  input  logic       gen_ready,
  input  logic [2:0] gen_piece,
  input  logic       take,
  output logic       next_valid,
  output logic [2:0] next_piece,
  output logic [2:0] preview_piece,
  output logic [3:0] count,
  output logic [7:0] reject_count,
  output logic [6:0] bag_mask
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_next;
  logic [3:0]    count_q, count_d;
  logic [7:0]    rej_q, rej_d;

  logic offered;
  logic piece_legal;
  logic accept;
  logic reject_c;
  logic take_ok;

  // Pointer increment that wraps at DEPTH. DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // A candidate only counts as offered while gen_enable is high. This
  // filters out gen_ready during reset and in HOLD.
  assign offered  = gen_enable && gen_ready;
  assign accept   = offered && piece_legal;
  assign reject_c = offered && !piece_legal;
  assign take_ok  = take && (count_q != 4'd0);
  assign rd_next  = ptr_inc(rd_ptr_q);

`ifdef PIECE_BAG_EN
  logic [6:0] bag_q, bag_d;
  logic [6:0] piece_oh;
  logic [6:0] bag_set;

  // Code 7 shifts the one-hot value out of range, so piece_oh becomes 0.
  // Code 7 is already rejected by the legality test below.
  assign piece_oh    = 7'd1 << gen_piece;
  assign piece_legal = (gen_piece != 3'd7) && ((bag_q & piece_oh) == 7'd0);

  // Next bag mask: mark the accepted piece. When the bag fills, start a
  // new bag in the same update.
  always_comb begin
    bag_d   = bag_q;
    bag_set = bag_q | piece_oh;
    if (accept) begin
      if (bag_set == 7'h7F) begin
        bag_d = 7'd0;
      end else begin
        bag_d = bag_set;
      end
    end else begin
      bag_d = bag_q;
    end
  end

  // Bag mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      bag_q <= 7'd0;
    end else begin
      bag_q <= bag_d;
    end
  end

  assign bag_mask = bag_q;
`else
  assign piece_legal = (gen_piece != 3'd7);
  assign bag_mask    = 7'd0;
`endif

  // Next-state logic for the pointers, the occupancy and the reject counter
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rej_d    = rej_q;
    if (accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (take_ok) begin
      rd_ptr_d = rd_next;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept, take_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (reject_c && (rej_q != 8'hFF)) begin
      rej_d = rej_q + 8'd1;
    end else begin
      rej_d = rej_q;
    end
  end

  // FSM next state and the generator request. Reset forces the request low.
  always_comb begin
    state_d    = state_q;
    gen_enable = (state_q == FILL) && !reset;
    case (state_q)
      FILL: begin
        if (count_d == DEPTH_C) begin
          state_d = HOLD;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (take) begin
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, pointer and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
      rej_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rej_q    <= rej_d;
    end
  end

  // FIFO storage: write an accepted piece at the tail
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 3'd0;
      end
    end else if (accept) begin
      fifo_q[wr_ptr_q] <= gen_piece;
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  // The outputs depend only on registered state. Entries past the current
  // count may be stale, so those outputs are gated to 0.
  assign next_valid    = (count_q != 4'd0);
  assign next_piece    = next_valid ? fifo_q[rd_ptr_q] : 3'd0;
  assign preview_piece = (count_q >= 4'd2) ? fifo_q[rd_next] : 3'd0;
  assign count         = count_q;
  assign reject_count  = rej_q;

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Testbench for piece_queue_ctrl (DEPTH = 4). It uses three kinds of
// stimulus: a directed vector table, a hand-written bag sequence and a long
// random run. Every cycle, the outputs are compared with a queue-based
// reference model.
module tb_piece_queue_ctrl;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       gen_enable;
  logic       gen_ready;
  logic [2:0] gen_piece;
  logic       take;
  logic       next_valid;
  logic [2:0] next_piece;
  logic [2:0] preview_piece;
  logic [3:0] count;
  logic [7:0] reject_count;
  logic [6:0] bag_mask;

  piece_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .gen_enable   (gen_enable),
    .gen_ready    (gen_ready),
    .gen_piece    (gen_piece),
    .take         (take),
    .next_valid   (next_valid),
    .next_piece   (next_piece),
    .preview_piece(preview_piece),
    .count        (count),
    .reject_count (reject_count),
    .bag_mask     (bag_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_q[$];
  int m_rej = 0;
  int m_bag = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_gen_en(input logic r);
    return (!r && (m_q.size() < DEPTH)) ? 1 : 0;
  endfunction

  // Applies the model rules for one rising edge with the current inputs.
  task automatic model_edge();
    int  en;
    bit  legal;
    if (reset) begin
      m_q.delete();
      m_rej = 0;
      m_bag = 0;
    end else begin
      en    = model_gen_en(1'b0);
      legal = (gen_piece != 3'd7);
`ifdef PIECE_BAG_EN
      if (legal && m_bag[gen_piece]) legal = 1'b0;
`endif
      if (take && m_q.size() > 0) void'(m_q.pop_front());
      if (en != 0 && gen_ready) begin
        if (legal) begin
          m_q.push_back(int'(gen_piece));
`ifdef PIECE_BAG_EN
          m_bag = m_bag | (1 << gen_piece);
          if (m_bag == 127) m_bag = 0;
`endif
        end else if (m_rej < 255) begin
          m_rej++;
        end
      end
    end
  endtask

  // Drives one cycle of inputs and checks gen_enable before the edge.
  // After the edge it compares every output with the model.
  task automatic step(input logic r, input logic gr, input logic [2:0] gp, input logic tk);
    reset = r; gen_ready = gr; gen_piece = gp; take = tk;
    #1;
    chk("gen_enable_pre", int'(gen_enable), model_gen_en(r));
    @(posedge clk);
    model_edge();
    #1;
    chk("m_count",   int'(count),         m_q.size());
    chk("m_valid",   int'(next_valid),    (m_q.size() > 0) ? 1 : 0);
    chk("m_next",    int'(next_piece),    (m_q.size() > 0) ? m_q[0] : 0);
    chk("m_preview", int'(preview_piece), (m_q.size() > 1) ? m_q[1] : 0);
    chk("m_reject",  int'(reject_count),  m_rej);
    chk("m_bag",     int'(bag_mask),      m_bag);
  endtask

  typedef struct {
    logic       r;
    logic       gr;
    logic [2:0] gp;
    logic       tk;
    int         e_cnt;
    int         e_next;
    int         e_prev;
    int         e_rej;
    int         e_gen;
  } vec_t;

  vec_t tbl[20];

  initial begin
    reset = 1'b1; gen_ready = 1'b0; gen_piece = 3'd0; take = 1'b0;
    @(posedge clk); #1;

    //           r     gr    gp    tk    cnt nxt prv rej gen
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 0};  // reset
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 1};  // idle
    tbl[2]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1, 3, 0, 0, 1};
    tbl[3]  = '{1'b0, 1'b1, 3'd5, 1'b0, 2, 3, 5, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, 3'd1, 1'b0, 3, 3, 5, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 3'd6, 1'b0, 4, 3, 5, 0, 0};  // full -> HOLD
    tbl[6]  = '{1'b0, 1'b1, 3'd2, 1'b0, 4, 3, 5, 0, 0};  // ignored in HOLD
    tbl[7]  = '{1'b0, 1'b1, 3'd2, 1'b1, 3, 5, 1, 0, 1};  // take in HOLD
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2, 1, 6, 0, 1};
    tbl[9]  = '{1'b0, 1'b1, 3'd4, 1'b1, 2, 6, 4, 0, 1};  // take + accept
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b1, 1, 4, 0, 0, 1};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 0, 0, 0, 0, 1};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 0, 0, 0, 0, 1};  // take when empty
    tbl[13] = '{1'b0, 1'b1, 3'd7, 1'b0, 0, 0, 0, 1, 1};  // invalid code
    tbl[14] = '{1'b0, 1'b1, 3'd0, 1'b0, 1, 0, 0, 1, 1};
    tbl[15] = '{1'b0, 1'b1, 3'd2, 1'b0, 2, 0, 2, 1, 1};
    tbl[16] = '{1'b0, 1'b1, 3'd2, 1'b0, 3, 0, 2, 1, 1};
    tbl[17] = '{1'b1, 1'b1, 3'd2, 1'b1, 0, 0, 0, 0, 0};  // reset beats take
    tbl[18] = '{1'b1, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 0};
    tbl[19] = '{1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].gr, tbl[i].gp, tbl[i].tk);
      chk($sformatf("tbl%0d_count", i),   int'(count),         tbl[i].e_cnt);
      chk($sformatf("tbl%0d_next", i),    int'(next_piece),    tbl[i].e_next);
      chk($sformatf("tbl%0d_preview", i), int'(preview_piece), tbl[i].e_prev);
      chk($sformatf("tbl%0d_reject", i),  int'(reject_count),  tbl[i].e_rej);
      chk($sformatf("tbl%0d_gen_en", i),  int'(gen_enable),    tbl[i].e_gen);
    end

    // Offer the same piece twice in a row
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b0);
`ifdef PIECE_BAG_EN
    chk("bag_dup_reject", int'(reject_count), 1);
    chk("bag_dup_mask",   int'(bag_mask),     7'b0000100);
    chk("bag_dup_count",  int'(count),        1);
    // Deal the rest of the bag, popping one piece each cycle
    begin
      int rest[6] = '{0, 1, 3, 4, 5, 6};
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'(rest[i]), 1'b1);
    end
    chk("bag_clear_mask",  int'(bag_mask),   0);
    chk("bag_clear_count", int'(count),      1);
    chk("bag_clear_next",  int'(next_piece), 6);
`else
    chk("nobag_dup_reject", int'(reject_count), 0);
    chk("nobag_dup_mask",   int'(bag_mask),     0);
    chk("nobag_dup_count",  int'(count),        2);
`endif

    // Saturation of the reject counter
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 3'd7, 1'b0);
    chk("reject_saturate", int'(reject_count), 255);

    // Random run
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
